// File: rtl/rob_commit_unit.sv
// Reorder buffer: hands out rename tags, collects CDB results, retires in program order, flushes on mispredict.
// Optional same-cycle CDB bypass for operand resolution and head commit: define ROB_BYPASS_EN.
module rob_commit_unit #(
    parameter int ROB_ID_WIDTH = 3,
    parameter int VAL_WIDTH    = 32,
    parameter int REG_WIDTH    = 5
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  issue_en,
    input  logic [REG_WIDTH-1:0]  issue_rd,
    input  logic                  issue_is_br,
    output logic [ROB_ID_WIDTH:0] rob_tag,
    output logic                  rob_full,
    input  logic                  cdb_en,
    input  logic [ROB_ID_WIDTH:0] cdb_lab,
    input  logic [VAL_WIDTH-1:0]  cdb_val,
    input  logic                  cdb_mispredict,
    input  logic [VAL_WIDTH-1:0]  cdb_target,
    input  logic [ROB_ID_WIDTH:0] rf_lab1,
    input  logic [ROB_ID_WIDTH:0] rf_lab2,
    input  logic [VAL_WIDTH-1:0]  rf_val1,
    input  logic [VAL_WIDTH-1:0]  rf_val2,
    output logic [ROB_ID_WIDTH:0] opr_lab1,
    output logic [ROB_ID_WIDTH:0] opr_lab2,
    output logic [VAL_WIDTH-1:0]  opr_val1,
    output logic [VAL_WIDTH-1:0]  opr_val2,
    output logic                  commit_en,
    output logic [REG_WIDTH-1:0]  commit_rd,
    output logic [VAL_WIDTH-1:0]  commit_res,
    output logic [ROB_ID_WIDTH:0] commit_lab,
    output logic                  flush,
    output logic [VAL_WIDTH-1:0]  flush_pc,
    output logic                  dbg_state_o,
    output logic [ROB_ID_WIDTH:0] dbg_count_o
);

    localparam int DEPTH = 1 << ROB_ID_WIDTH;

    typedef logic [ROB_ID_WIDTH-1:0] idx_t;
    typedef logic [ROB_ID_WIDTH:0]   tag_t;
    typedef logic [VAL_WIDTH-1:0]    val_t;

    localparam idx_t IDX_ONE  = idx_t'(1);
    localparam tag_t TAG_ONE  = tag_t'(1);
    localparam tag_t TAG_ZERO = tag_t'(0);
    localparam tag_t CNT_FULL = {1'b1, {ROB_ID_WIDTH{1'b0}}};

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e state_q;
    idx_t   head_q, head_d;
    idx_t   tail_q, tail_d;
    tag_t   count_q, count_d;

    logic                 busy_q  [DEPTH];
    logic                 ready_q [DEPTH];
    logic [REG_WIDTH-1:0] rd_q    [DEPTH];
    val_t                 val_q   [DEPTH];
    logic                 is_br_q [DEPTH];
    logic                 misp_q  [DEPTH];
    val_t                 tgt_q   [DEPTH];

    logic                 commit_en_q;
    logic [REG_WIDTH-1:0] commit_rd_q;
    val_t                 commit_res_q;
    tag_t                 commit_lab_q;
    logic                 flush_q;
    val_t                 flush_pc_q;

    logic run_w, issue_go, cdb_go, commit_go, head_cdb, head_rdy, head_flush;
    logic head_misp;
    idx_t cdb_idx;
    tag_t head_tag;
    val_t head_val, head_tgt;

    function automatic idx_t tag2idx(input tag_t t);
        return idx_t'(t - TAG_ONE);
    endfunction

    // Acceptance rules: an issue is taken when issue_en && !rob_full in RUN with rdy_in high;
    // rob_full reflects only the current count, so a same-cycle commit never frees a slot for issue.
    // A CDB write lands only on a busy entry; a commit fires when the head entry is ready.
    assign run_w    = rdy_in && (state_q == ST_RUN);
    assign rob_full = (count_q == CNT_FULL);
    assign rob_tag  = tag_t'({1'b0, tail_q}) + TAG_ONE;
    assign issue_go = run_w && issue_en && !rob_full;
    assign cdb_idx  = tag2idx(cdb_lab);
    assign cdb_go   = run_w && cdb_en && (cdb_lab != TAG_ZERO) && busy_q[cdb_idx];
    assign head_tag = tag_t'({1'b0, head_q}) + TAG_ONE;

`ifdef ROB_BYPASS_EN
    assign head_cdb = cdb_go && (cdb_lab == head_tag);
`else
    assign head_cdb = 1'b0;
`endif

    assign head_rdy   = ready_q[head_q] || head_cdb;
    assign commit_go  = run_w && (count_q != TAG_ZERO) && head_rdy;
    assign head_flush = commit_go && is_br_q[head_q] && head_misp;

    // A head made ready only by the same-cycle CDB takes its payload straight from the bus.
    always_comb begin
        head_val  = val_q[head_q];
        head_misp = misp_q[head_q];
        head_tgt  = tgt_q[head_q];
        if (!ready_q[head_q]) begin
            head_val  = cdb_val;
            head_misp = cdb_mispredict;
            head_tgt  = cdb_target;
        end
    end

    function automatic logic [ROB_ID_WIDTH+VAL_WIDTH:0] resolve(input tag_t lab, input val_t val);
        logic [ROB_ID_WIDTH+VAL_WIDTH:0] r;
        r = {lab, val};
        if (lab != TAG_ZERO && ready_q[tag2idx(lab)]) begin
            r = {TAG_ZERO, val_q[tag2idx(lab)]};
        end
`ifdef ROB_BYPASS_EN
        if (lab != TAG_ZERO && cdb_en && cdb_lab == lab) begin
            r = {TAG_ZERO, cdb_val};
        end
`endif
        return r;
    endfunction

    assign {opr_lab1, opr_val1} = resolve(rf_lab1, rf_val1);
    assign {opr_lab2, opr_val2} = resolve(rf_lab2, rf_val2);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy_in && state_q == ST_FLUSH) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue_go) begin
                tail_d = tail_q + IDX_ONE;
            end
            if (commit_go) begin
                head_d = head_q + IDX_ONE;
            end
            if (issue_go && !commit_go) begin
                count_d = count_q + TAG_ONE;
            end else if (!issue_go && commit_go) begin
                count_d = count_q - TAG_ONE;
            end
        end
    end

    // Entry storage; the commit free is written last so it wins over a same-cycle CDB write to head.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
                misp_q[i]  <= 1'b0;
            end
        end else if (rdy_in) begin
            if (state_q == ST_FLUSH) begin
                for (int i = 0; i < DEPTH; i++) begin
                    busy_q[i]  <= 1'b0;
                    ready_q[i] <= 1'b0;
                end
            end else begin
                if (issue_go) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    rd_q[tail_q]    <= issue_rd;
                    is_br_q[tail_q] <= issue_is_br;
                    misp_q[tail_q]  <= 1'b0;
                end
                if (cdb_go) begin
                    ready_q[cdb_idx] <= 1'b1;
                    val_q[cdb_idx]   <= cdb_val;
                    misp_q[cdb_idx]  <= cdb_mispredict;
                    tgt_q[cdb_idx]   <= cdb_target;
                end
                if (commit_go) begin
                    busy_q[head_q]  <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q      <= ST_RUN;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            commit_en_q  <= 1'b0;
            commit_rd_q  <= '0;
            commit_res_q <= '0;
            commit_lab_q <= '0;
            flush_q      <= 1'b0;
            flush_pc_q   <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            commit_en_q <= 1'b0;
            flush_q     <= 1'b0;
            if (rdy_in) begin
                case (state_q)
                    ST_RUN: begin
                        commit_en_q <= commit_go;
                        if (commit_go) begin
                            commit_rd_q  <= rd_q[head_q];
                            commit_res_q <= head_val;
                            commit_lab_q <= head_tag;
                            if (head_flush) begin
                                flush_pc_q <= head_tgt;
                                state_q    <= ST_FLUSH;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        flush_q <= 1'b1;
                        state_q <= ST_RUN;
                    end
                    default: state_q <= ST_RUN;
                endcase
            end
        end
    end

    assign commit_en   = commit_en_q;
    assign commit_rd   = commit_rd_q;
    assign commit_res  = commit_res_q;
    assign commit_lab  = commit_lab_q;
    assign flush       = flush_q;
    assign flush_pc    = flush_pc_q;
    assign dbg_state_o = state_q;
    assign dbg_count_o = count_q;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: tag allocation, commit, full/wrap, mispredict flush, operand resolution, stall, reset.
module tb_rob_commit_unit;
    localparam int IDW = 3;
    localparam int VW  = 32;
    localparam int RW  = 5;
`ifdef ROB_BYPASS_EN
    localparam int CDB_LAT = 1;
`else
    localparam int CDB_LAT = 2;
`endif
    localparam bit LATE = (CDB_LAT == 2);
    localparam bit BYP  = (CDB_LAT == 1);

    logic           clk;
    logic           rst_in, rdy_in;
    logic           issue_en, issue_is_br;
    logic [RW-1:0]  issue_rd;
    logic [IDW:0]   rob_tag;
    logic           rob_full;
    logic           cdb_en, cdb_mispredict;
    logic [IDW:0]   cdb_lab;
    logic [VW-1:0]  cdb_val, cdb_target;
    logic [IDW:0]   rf_lab1, rf_lab2, opr_lab1, opr_lab2;
    logic [VW-1:0]  rf_val1, rf_val2, opr_val1, opr_val2;
    logic           commit_en;
    logic [RW-1:0]  commit_rd;
    logic [VW-1:0]  commit_res;
    logic [IDW:0]   commit_lab;
    logic           flush;
    logic [VW-1:0]  flush_pc;
    logic           dbg_state_o;
    logic [IDW:0]   dbg_count_o;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [RW+VW+IDW:0] exp_q[$];

    rob_commit_unit dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
        .rob_tag(rob_tag), .rob_full(rob_full),
        .cdb_en(cdb_en), .cdb_lab(cdb_lab), .cdb_val(cdb_val),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .rf_lab1(rf_lab1), .rf_lab2(rf_lab2), .rf_val1(rf_val1), .rf_val2(rf_val2),
        .opr_lab1(opr_lab1), .opr_lab2(opr_lab2), .opr_val1(opr_val1), .opr_val2(opr_val2),
        .commit_en(commit_en), .commit_rd(commit_rd), .commit_res(commit_res),
        .commit_lab(commit_lab), .flush(flush), .flush_pc(flush_pc),
        .dbg_state_o(dbg_state_o), .dbg_count_o(dbg_count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Commit scoreboard: every commit strobe must match the oldest expected {rd, result, tag}.
    always @(negedge clk) begin
        if (commit_en) begin
            check_eq("commit_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                check_eq("commit_word", 64'({commit_rd, commit_res, commit_lab}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic push_commit(input logic [RW-1:0] rd, input logic [VW-1:0] res, input logic [IDW:0] lab);
        exp_q.push_back({rd, res, lab});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_idle();
        rdy_in = 1'b1; issue_en = 1'b0; issue_rd = '0; issue_is_br = 1'b0;
        cdb_en = 1'b0; cdb_lab = '0; cdb_val = '0; cdb_mispredict = 1'b0; cdb_target = '0;
        rf_lab1 = '0; rf_lab2 = '0; rf_val1 = '0; rf_val2 = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic issue_one(input logic [RW-1:0] rd, input logic br);
        issue_en = 1'b1; issue_rd = rd; issue_is_br = br;
        tick();
        issue_en = 1'b0; issue_is_br = 1'b0;
    endtask

    task automatic cdb_write(input logic [IDW:0] lab, input logic [VW-1:0] val,
                             input logic misp, input logic [VW-1:0] tgt);
        cdb_en = 1'b1; cdb_lab = lab; cdb_val = val; cdb_mispredict = misp; cdb_target = tgt;
        tick();
        cdb_en = 1'b0; cdb_mispredict = 1'b0;
    endtask

    task automatic wait_commit(input string tag);
        for (int i = 1; i < CDB_LAT; i++) begin
            #1 check_eq({tag, "_early"}, 64'(commit_en), 64'(0));
            tick();
        end
        #1 check_eq({tag, "_en"}, 64'(commit_en), 64'(1));
    endtask

    initial begin
        drive_idle();
        rst_in = 1'b1;
        do_reset();

        // Tag allocation, no commit without results
        issue_en = 1'b1; issue_rd = 5'd5;
        #1 check_eq("t2_tag1", 64'(rob_tag), 64'(1));
        tick();
        issue_rd = 5'd6;
        #1 check_eq("t2_tag2", 64'(rob_tag), 64'(2));
        tick();
        issue_en = 1'b0;
        #1 check_eq("t2_count", 64'(dbg_count_o), 64'(2));
        check_eq("t2_no_commit", 64'(commit_en), 64'(0));

        // Single result commits in order
        do_reset();
        issue_one(5'd3, 1'b0);
        push_commit(5'd3, 32'h1234, 4'd1);
        cdb_write(4'd1, 32'h1234, 1'b0, '0);
        wait_commit("t3");
        check_eq("t3_rd", 64'(commit_rd), 64'(3));
        check_eq("t3_res", 64'(commit_res), 64'h1234);
        check_eq("t3_lab", 64'(commit_lab), 64'(1));
        tick();
        #1 check_eq("t3_pulse", 64'(commit_en), 64'(0));
        check_eq("t3_count", 64'(dbg_count_o), 64'(0));

        // Reset clears registered commit outputs left over from above
        do_reset();
        #1 check_eq("rst_commit_en", 64'(commit_en), 64'(0));
        check_eq("rst_commit_rd", 64'(commit_rd), 64'(0));
        check_eq("rst_commit_res", 64'(commit_res), 64'(0));
        check_eq("rst_commit_lab", 64'(commit_lab), 64'(0));
        check_eq("rst_flush", 64'(flush), 64'(0));
        check_eq("rst_tag", 64'(rob_tag), 64'(1));
        check_eq("rst_full", 64'(rob_full), 64'(0));

        // Fill, overflow attempt, commit one, wrap
        for (int i = 0; i < 8; i++) begin
            issue_en = 1'b1; issue_rd = RW'(i + 1);
            #1 check_eq("t4_fill_tag", 64'(rob_tag), 64'(i + 1));
            tick();
        end
        issue_rd = 5'd9;
        #1 check_eq("t4_full", 64'(rob_full), 64'(1));
        tick();
        issue_en = 1'b0;
        #1 check_eq("t4_ovf_count", 64'(dbg_count_o), 64'(8));
        check_eq("t4_ovf_tag", 64'(rob_tag), 64'(1));
        push_commit(5'd1, 32'h0000_00aa, 4'd1);
        cdb_write(4'd1, 32'h0000_00aa, 1'b0, '0);
        wait_commit("t4");
        check_eq("t4_not_full", 64'(rob_full), 64'(0));
        check_eq("t4_count7", 64'(dbg_count_o), 64'(7));
        check_eq("t4_wrap_tag", 64'(rob_tag), 64'(1));
        issue_one(5'd10, 1'b0);
        #1 check_eq("t4_tag_after_wrap", 64'(rob_tag), 64'(2));
        check_eq("t4_full_again", 64'(rob_full), 64'(1));
        cdb_write(4'd8, 32'h0000_0088, 1'b0, '0);
        rf_lab1 = 4'd8; rf_val1 = 32'hdead; rf_lab2 = 4'd1; rf_val2 = 32'hbeef;
        #1 check_eq("t4_lab8", 64'(opr_lab1), 64'(0));
        check_eq("t4_val8", 64'(opr_val1), 64'h88);
        check_eq("t4_reissued_lab", 64'(opr_lab2), 64'(1));
        check_eq("t4_reissued_val", 64'(opr_val2), 64'hbeef);

        // Mispredicted branch: commit, flush pulse, clean restart
        do_reset();
        issue_one(5'd1, 1'b1);
        issue_one(5'd2, 1'b0);
        push_commit(5'd1, 32'h40, 4'd1);
        cdb_write(4'd1, 32'h40, 1'b1, 32'h100);
        wait_commit("t5");
        check_eq("t5_no_flush_yet", 64'(flush), 64'(0));
        check_eq("t5_state_flush", 64'(dbg_state_o), 64'(1));
        issue_en = 1'b1; issue_rd = 5'd7;
        tick();
        issue_en = 1'b0;
        #1 check_eq("t5_flush", 64'(flush), 64'(1));
        check_eq("t5_flush_pc", 64'(flush_pc), 64'h100);
        check_eq("t5_flush_no_commit", 64'(commit_en), 64'(0));
        check_eq("t5_tag", 64'(rob_tag), 64'(1));
        check_eq("t5_full", 64'(rob_full), 64'(0));
        check_eq("t5_count", 64'(dbg_count_o), 64'(0));
        tick();
        #1 check_eq("t5_flush_drop", 64'(flush), 64'(0));
        check_eq("t5_state_run", 64'(dbg_state_o), 64'(0));

        // Operand resolution
        do_reset();
        cdb_write(4'd1, 32'd5, 1'b0, '0);
        rf_lab1 = 4'd1; rf_val1 = 32'h77;
        #1 check_eq("t6_idle_cdb_lab", 64'(opr_lab1), 64'(1));
        check_eq("t6_idle_cdb_val", 64'(opr_val1), 64'h77);
        issue_one(5'd1, 1'b0);
        issue_one(5'd2, 1'b0);
        issue_one(5'd3, 1'b0);
        cdb_write(4'd2, 32'd7, 1'b0, '0);
        rf_lab1 = 4'd2; rf_val1 = 32'h99;
        #1 check_eq("t6_ready_lab", 64'(opr_lab1), 64'(0));
        check_eq("t6_ready_val", 64'(opr_val1), 64'(7));
        cdb_en = 1'b1; cdb_lab = 4'd3; cdb_val = 32'd9;
        rf_lab2 = 4'd3; rf_val2 = 32'h11;
        #1 check_eq("t6_byp_lab", 64'(opr_lab2), BYP ? 64'(0) : 64'(3));
        check_eq("t6_byp_val", 64'(opr_val2), BYP ? 64'(9) : 64'h11);
        tick();
        cdb_en = 1'b0;
        #1 check_eq("t6_after_lab", 64'(opr_lab2), 64'(0));
        check_eq("t6_after_val", 64'(opr_val2), 64'(9));

        // Stall holds a ready head
        do_reset();
        issue_one(5'd4, 1'b0);
        push_commit(5'd4, 32'h21, 4'd1);
        cdb_write(4'd1, 32'h21, 1'b0, '0);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1 check_eq("t7_stall_commit", 64'(commit_en), 64'(0));
        end
        check_eq("t7_stall_count", 64'(dbg_count_o), 64'(LATE));
        rdy_in = 1'b1;
        tick();
        #1 check_eq("t7_resume_commit", 64'(commit_en), 64'(LATE));
        check_eq("t7_resume_count", 64'(dbg_count_o), 64'(0));

        // Reset while in FLUSH
        do_reset();
        issue_one(5'd2, 1'b1);
        push_commit(5'd2, 32'h0, 4'd1);
        cdb_write(4'd1, 32'h0, 1'b1, 32'h200);
        wait_commit("t8");
        check_eq("t8_in_flush", 64'(dbg_state_o), 64'(1));
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        #1 check_eq("t8_flush", 64'(flush), 64'(0));
        check_eq("t8_count", 64'(dbg_count_o), 64'(0));
        check_eq("t8_state", 64'(dbg_state_o), 64'(0));
        check_eq("t8_flush_pc", 64'(flush_pc), 64'(0));
        tick();
        #1 check_eq("t8_flush_after", 64'(flush), 64'(0));

        check_eq("sb_drain", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
